// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative
// shift-add unsigned multiply. Each result is held until the consumer takes it.
module alu_seq #(
  parameter int N    = 8,
  parameter int NSel = 6
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [N-1:0]    i_alu_A,
  input  logic [N-1:0]    i_alu_B,
  input  logic [NSel-1:0] i_alu_Op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N-1:0]    o_alu_Result,
  output logic [N-1:0]    o_alu_Result_hi,
  output logic            o_zero,
  output logic            o_carry,
  output logic            o_overflow,
  output logic            o_err
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  localparam logic [NSel-1:0] OP_ADD   = NSel'(6'b100000);
  localparam logic [NSel-1:0] OP_SUB   = NSel'(6'b100010);
  localparam logic [NSel-1:0] OP_AND   = NSel'(6'b100100);
  localparam logic [NSel-1:0] OP_OR    = NSel'(6'b100101);
  localparam logic [NSel-1:0] OP_XOR   = NSel'(6'b100110);
  localparam logic [NSel-1:0] OP_SRA   = NSel'(6'b000011);
  localparam logic [NSel-1:0] OP_SRL   = NSel'(6'b000010);
  localparam logic [NSel-1:0] OP_NOR   = NSel'(6'b100111);
  localparam logic [NSel-1:0] OP_MULTU = NSel'(6'b011001);

  localparam int CW = $clog2(N);

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic [NSel-1:0] op_q;
  logic [N-1:0]    acc_hi_q, acc_lo_q;
  logic [CW-1:0]   cnt_q;

  logic [N:0]      sum, diff, mul_sum;
  logic [N-1:0]    ex_res, acc_hi_next, acc_lo_next;
  logic            ex_carry, ex_ovf, ex_err, mul_last;

  // Single-cycle datapath evaluated on the captured operands.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    ex_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_res   = sum[N-1:0];
        ex_carry = sum[N];
        ex_ovf   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        ex_res   = diff[N-1:0];
        ex_carry = diff[N];
        ex_ovf   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
      end
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_NOR:  ex_res = ~(a_q | b_q);
      OP_SRL:  ex_res = a_q >> b_q;
      OP_SRA:  ex_res = $signed(a_q) >>> b_q;
      default: ex_err = 1'b1;
    endcase
  end

  // One shift-add step: the multiplier sits in acc_lo and is consumed LSB first.
  always_comb begin
    mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    acc_hi_next = mul_sum[N:1];
    acc_lo_next = {mul_sum[0], acc_lo_q[N-1:1]};
    mul_last    = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = (i_alu_Op == OP_MULTU) ? MUL : EXEC;
      EXEC:    state_d = DONE;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every register, operands included, is reset so an aborted operation leaves no trace.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      acc_hi_q        <= '0;
      acc_lo_q        <= '0;
      cnt_q           <= '0;
      o_alu_Result    <= '0;
      o_alu_Result_hi <= '0;
      o_zero          <= 1'b0;
      o_carry         <= 1'b0;
      o_overflow      <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          a_q      <= i_alu_A;
          b_q      <= i_alu_B;
          op_q     <= i_alu_Op;
          acc_hi_q <= '0;
          acc_lo_q <= i_alu_B;
          cnt_q    <= '0;
        end
        EXEC: begin
          o_alu_Result    <= ex_res;
          o_alu_Result_hi <= '0;
          o_zero          <= (ex_res == '0);
          o_carry         <= ex_carry;
          o_overflow      <= ex_ovf;
          o_err           <= ex_err;
        end
        MUL: begin
          acc_hi_q <= acc_hi_next;
          acc_lo_q <= acc_lo_next;
          cnt_q    <= cnt_q + 1'b1;
          if (mul_last) begin
            o_alu_Result    <= acc_lo_next;
            o_alu_Result_hi <= acc_hi_next;
            o_zero          <= ({acc_hi_next, acc_lo_next} == '0);
            o_carry         <= 1'b0;
            o_overflow      <= (acc_hi_next != '0);
            o_err           <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);

endmodule
